// File: rtl/noc_sim_ctrl.sv
// Simulation controller for a bank of NoC traffic generators: starts a run,
// counts sent/received packets, drains the network, then reports once.
module noc_sim_ctrl #(
  parameter int NE           = 16,
  parameter int MAX_PCK_NUM  = 10000,
  parameter int MAX_SIM_CLKs = 100000,
  parameter int DRAIN_MAX    = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sim_en,
  input  logic [6:0]    ratio_in,
  input  logic [NE-1:0] sent_done,
  input  logic [NE-1:0] update,
  output logic          start,
  output logic [6:0]    ratio_out,
  output logic          report,
  output logic          done,
  output logic          drain_timeout,
  output logic [2:0]    state,
  output logic [31:0]   clk_cnt,
  output logic [31:0]   total_sent,
  output logic [31:0]   total_recv
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [31:0] PCK_LIMIT  = 32'(MAX_PCK_NUM);
  localparam logic [31:0] CLK_LIMIT  = 32'(MAX_SIM_CLKs);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_MAX - 1);

  state_t      cur;
  logic [31:0] drain_cnt;
  logic [31:0] sent_sum;
  logic [31:0] recv_sum;
  logic        counting;
  logic        run_exit;

  function automatic logic [31:0] popcount(input logic [NE-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NE; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // sent_done/update are one-cycle pulses per generator; every high bit in a
  // cycle is one packet, so several generators finishing together all count.
  assign sent_sum  = sat_add(total_sent, popcount(sent_done));
  assign recv_sum  = sat_add(total_recv, popcount(update));
  assign counting  = (cur == S_RUN) || (cur == S_DRAIN) || (cur == S_REPORT);
  assign run_exit  = (total_sent >= PCK_LIMIT) || (clk_cnt >= CLK_LIMIT) || !sim_en;
  assign state     = cur;
  assign ratio_out = (cur == S_RUN) ? ratio_in : 7'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur           <= S_IDLE;
      start         <= 1'b0;
      report        <= 1'b0;
      done          <= 1'b0;
      drain_timeout <= 1'b0;
      clk_cnt       <= '0;
      total_sent    <= '0;
      total_recv    <= '0;
      drain_cnt     <= '0;
    end else begin
      start  <= 1'b0;
      report <= 1'b0;
      if (counting) begin
        total_sent <= sent_sum;
        total_recv <= recv_sum;
      end
      case (cur)
        S_IDLE: begin
          if (sim_en) begin
            cur           <= S_START;
            start         <= 1'b1;
            clk_cnt       <= '0;
            total_sent    <= '0;
            total_recv    <= '0;
            drain_timeout <= 1'b0;
            drain_cnt     <= '0;
          end
        end
        S_START: begin
          clk_cnt       <= '0;
          total_sent    <= '0;
          total_recv    <= '0;
          drain_timeout <= 1'b0;
          drain_cnt     <= '0;
          cur           <= S_RUN;
        end
        S_RUN: begin
          // clk_cnt stops on the decision cycle so it reads the limit in DRAIN
          if (run_exit) cur <= S_DRAIN;
          else if (clk_cnt != '1) clk_cnt <= clk_cnt + 32'd1;
        end
        S_DRAIN: begin
          if (drain_cnt != '1) drain_cnt <= drain_cnt + 32'd1;
          if (total_recv >= total_sent) begin
            cur    <= S_REPORT;
            report <= 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            cur           <= S_REPORT;
            report        <= 1'b1;
            drain_timeout <= 1'b1;
          end
        end
        S_REPORT: begin
          cur  <= S_DONE;
          done <= 1'b1;
        end
        S_DONE: begin
          if (!sim_en) begin
            cur  <= S_IDLE;
            done <= 1'b0;
          end
        end
        default: begin
          cur  <= S_IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_sim_ctrl.sv
// Directed bench for noc_sim_ctrl: normal run, clock limit, drain timeout,
// simultaneous pulses, abort and asynchronous reset.
module tb_noc_sim_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sim_en = 1'b0;
  logic [6:0]  ratio_in = '0;
  logic [3:0]  sent_done = '0;
  logic [3:0]  update = '0;
  logic        start, report, done, drain_timeout;
  logic [6:0]  ratio_out;
  logic [2:0]  state;
  logic [31:0] clk_cnt, total_sent, total_recv;

  int passed = 0;
  int total = 0;
  int start_seen = 0;
  int report_seen = 0;

  noc_sim_ctrl #(
    .NE(4), .MAX_PCK_NUM(8), .MAX_SIM_CLKs(20), .DRAIN_MAX(16)
  ) dut (
    .clk(clk), .reset(reset), .sim_en(sim_en), .ratio_in(ratio_in),
    .sent_done(sent_done), .update(update), .start(start), .ratio_out(ratio_out),
    .report(report), .done(done), .drain_timeout(drain_timeout), .state(state),
    .clk_cnt(clk_cnt), .total_sent(total_sent), .total_recv(total_recv)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start === 1'b1) start_seen++;
    if (report === 1'b1) report_seen++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) step();
    total++; if (state !== 3'd0) $display("FAIL rst_state: got %0d want 0", state); else passed++;
    total++; if (start !== 1'b0) $display("FAIL rst_start: got %0d want 0", start); else passed++;
    total++; if (report !== 1'b0) $display("FAIL rst_report: got %0d want 0", report); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %0d want 0", done); else passed++;
    total++; if (drain_timeout !== 1'b0) $display("FAIL rst_dto: got %0d want 0", drain_timeout); else passed++;
    total++; if (ratio_out !== 7'd0) $display("FAIL rst_ratio: got %0d want 0", ratio_out); else passed++;
    total++; if (clk_cnt !== 32'd0) $display("FAIL rst_clk_cnt: got %0d want 0", clk_cnt); else passed++;
    total++; if (total_sent !== 32'd0) $display("FAIL rst_sent: got %0d want 0", total_sent); else passed++;
    total++; if (total_recv !== 32'd0) $display("FAIL rst_recv: got %0d want 0", total_recv); else passed++;
    reset = 1'b1;
    sent_done = 4'b1111;
    update = 4'b1111;
    repeat (3) step();
    total++; if (state !== 3'd0) $display("FAIL idle_hold: got %0d want 0", state); else passed++;
    total++; if (total_sent !== 32'd0) $display("FAIL idle_ignore: got %0d want 0", total_sent); else passed++;
    sent_done = '0;
    update = '0;
  endtask

  task automatic test_normal_run();
    int s0, r0;
    s0 = start_seen;
    r0 = report_seen;
    sim_en = 1'b1;
    ratio_in = 7'd50;
    step();
    total++; if (state !== 3'd1) $display("FAIL nr_start_state: got %0d want 1", state); else passed++;
    total++; if (start !== 1'b1) $display("FAIL nr_start_pulse: got %0d want 1", start); else passed++;
    total++; if (ratio_out !== 7'd0) $display("FAIL nr_start_ratio: got %0d want 0", ratio_out); else passed++;
    step();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      case (k)
        0: begin
          total++; if (state !== 3'd2) $display("FAIL nr_run_state: got %0d want 2", state); else passed++;
          total++; if (ratio_out !== 7'd50) $display("FAIL nr_run_ratio: got %0d want 50", ratio_out); else passed++;
          total++; if (start !== 1'b0) $display("FAIL nr_start_once: got %0d want 0", start); else passed++;
        end
        4: begin
          total++; if (state !== 3'd2) $display("FAIL nr_k4_state: got %0d want 2", state); else passed++;
          total++; if (total_sent !== 32'd8) $display("FAIL nr_sent8: got %0d want 8", total_sent); else passed++;
        end
        5: begin
          total++; if (state !== 3'd3) $display("FAIL nr_drain_state: got %0d want 3", state); else passed++;
          total++; if (ratio_out !== 7'd0) $display("FAIL nr_drain_ratio: got %0d want 0", ratio_out); else passed++;
          total++; if (total_recv !== 32'd4) $display("FAIL nr_recv4: got %0d want 4", total_recv); else passed++;
        end
        7: begin
          total++; if (state !== 3'd3) $display("FAIL nr_k7_state: got %0d want 3", state); else passed++;
          total++; if (total_recv !== 32'd8) $display("FAIL nr_recv8: got %0d want 8", total_recv); else passed++;
        end
        8: begin
          total++; if (state !== 3'd4) $display("FAIL nr_report_state: got %0d want 4", state); else passed++;
          total++; if (report !== 1'b1) $display("FAIL nr_report_pulse: got %0d want 1", report); else passed++;
        end
        9: begin
          total++; if (state !== 3'd5) $display("FAIL nr_done_state: got %0d want 5", state); else passed++;
          total++; if (done !== 1'b1) $display("FAIL nr_done: got %0d want 1", done); else passed++;
          total++; if (drain_timeout !== 1'b0) $display("FAIL nr_dto: got %0d want 0", drain_timeout); else passed++;
          total++; if (total_recv !== 32'd8) $display("FAIL nr_final_recv: got %0d want 8", total_recv); else passed++;
        end
        default: ;
      endcase
      sent_done = (k < 4) ? 4'b0011 : 4'b0000;
      update = (k >= 3 && k < 7) ? 4'b1100 : 4'b0000;
    end
    total++; if (start_seen - s0 !== 1) $display("FAIL nr_start_count: got %0d want 1", start_seen - s0); else passed++;
    total++; if (report_seen - r0 !== 1) $display("FAIL nr_report_count: got %0d want 1", report_seen - r0); else passed++;
    sent_done = 4'b1111;
    update = 4'b1111;
    step();
    total++; if (state !== 3'd5) $display("FAIL done_hold_state: got %0d want 5", state); else passed++;
    total++; if (total_sent !== 32'd8) $display("FAIL done_hold_sent: got %0d want 8", total_sent); else passed++;
    total++; if (total_recv !== 32'd8) $display("FAIL done_hold_recv: got %0d want 8", total_recv); else passed++;
    sent_done = '0;
    update = '0;
    sim_en = 1'b0;
    step();
    total++; if (state !== 3'd0) $display("FAIL rearm_state: got %0d want 0", state); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rearm_done: got %0d want 0", done); else passed++;
    total++; if (total_sent !== 32'd8) $display("FAIL rearm_retain: got %0d want 8", total_sent); else passed++;
  endtask

  task automatic test_clock_limit();
    sim_en = 1'b1;
    ratio_in = 7'd25;
    step();
    total++; if (state !== 3'd1) $display("FAIL cl_start: got %0d want 1", state); else passed++;
    step();
    total++; if (ratio_out !== 7'd25) $display("FAIL cl_ratio: got %0d want 25", ratio_out); else passed++;
    total++; if (total_sent !== 32'd0) $display("FAIL cl_cleared: got %0d want 0", total_sent); else passed++;
    total++; if (clk_cnt !== 32'd0) $display("FAIL cl_cnt0: got %0d want 0", clk_cnt); else passed++;
    repeat (20) step();
    total++; if (state !== 3'd2) $display("FAIL cl_k20_state: got %0d want 2", state); else passed++;
    total++; if (clk_cnt !== 32'd20) $display("FAIL cl_k20_cnt: got %0d want 20", clk_cnt); else passed++;
    step();
    total++; if (state !== 3'd3) $display("FAIL cl_drain: got %0d want 3", state); else passed++;
    total++; if (clk_cnt !== 32'd20) $display("FAIL cl_drain_cnt: got %0d want 20", clk_cnt); else passed++;
    step();
    total++; if (report !== 1'b1) $display("FAIL cl_report: got %0d want 1", report); else passed++;
    step();
    total++; if (done !== 1'b1) $display("FAIL cl_done: got %0d want 1", done); else passed++;
    total++; if (drain_timeout !== 1'b0) $display("FAIL cl_dto: got %0d want 0", drain_timeout); else passed++;
    sim_en = 1'b0;
    step();
  endtask

  task automatic test_drain_timeout();
    int r0;
    r0 = report_seen;
    sim_en = 1'b1;
    ratio_in = 7'd10;
    step();
    step();
    sent_done = 4'b0111;
    step();
    sent_done = 4'b0011;
    step();
    sent_done = 4'b0000;
    update = 4'b0111;
    step();
    update = 4'b0000;
    total++; if (total_sent !== 32'd5) $display("FAIL dt_sent: got %0d want 5", total_sent); else passed++;
    total++; if (total_recv !== 32'd3) $display("FAIL dt_recv: got %0d want 3", total_recv); else passed++;
    repeat (33) step();
    total++; if (state !== 3'd3) $display("FAIL dt_last_drain: got %0d want 3", state); else passed++;
    total++; if (drain_timeout !== 1'b0) $display("FAIL dt_early: got %0d want 0", drain_timeout); else passed++;
    step();
    total++; if (state !== 3'd4) $display("FAIL dt_report_state: got %0d want 4", state); else passed++;
    total++; if (drain_timeout !== 1'b1) $display("FAIL dt_flag: got %0d want 1", drain_timeout); else passed++;
    step();
    total++; if (done !== 1'b1) $display("FAIL dt_done: got %0d want 1", done); else passed++;
    total++; if (total_recv !== 32'd3) $display("FAIL dt_final_recv: got %0d want 3", total_recv); else passed++;
    total++; if (report_seen - r0 !== 1) $display("FAIL dt_report_count: got %0d want 1", report_seen - r0); else passed++;
    sim_en = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    sim_en = 1'b1;
    ratio_in = 7'd60;
    step();
    step();
    sent_done = 4'b1111;
    update = 4'b1111;
    step();
    total++; if (total_sent !== 32'd4) $display("FAIL sim_sent4: got %0d want 4", total_sent); else passed++;
    total++; if (total_recv !== 32'd4) $display("FAIL sim_recv4: got %0d want 4", total_recv); else passed++;
    sent_done = 4'b0011;
    update = 4'b0000;
    step();
    sent_done = 4'b0000;
    total++; if (total_sent !== 32'd6) $display("FAIL sim_sent6: got %0d want 6", total_sent); else passed++;
    total++; if (state !== 3'd2) $display("FAIL sim_state: got %0d want 2", state); else passed++;
    total++; if (ratio_out !== 7'd60) $display("FAIL sim_ratio: got %0d want 60", ratio_out); else passed++;
  endtask

  task automatic test_abort_reset();
    int r0;
    r0 = report_seen;
    sim_en = 1'b0;
    step();
    total++; if (state !== 3'd3) $display("FAIL ab_drain: got %0d want 3", state); else passed++;
    total++; if (ratio_out !== 7'd0) $display("FAIL ab_ratio: got %0d want 0", ratio_out); else passed++;
    #1 reset = 1'b0;
    #1;
    total++; if (state !== 3'd0) $display("FAIL ar_state: got %0d want 0", state); else passed++;
    total++; if (total_sent !== 32'd0) $display("FAIL ar_sent: got %0d want 0", total_sent); else passed++;
    total++; if (total_recv !== 32'd0) $display("FAIL ar_recv: got %0d want 0", total_recv); else passed++;
    total++; if (clk_cnt !== 32'd0) $display("FAIL ar_clk_cnt: got %0d want 0", clk_cnt); else passed++;
    total++; if ({start, report, done, drain_timeout} !== 4'b0000) $display("FAIL ar_flags: got %b want 0000", {start, report, done, drain_timeout}); else passed++;
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    total++; if (report_seen - r0 !== 0) $display("FAIL ar_no_report: got %0d want 0", report_seen - r0); else passed++;
    total++; if (state !== 3'd0) $display("FAIL ar_wait_idle: got %0d want 0", state); else passed++;
    sim_en = 1'b1;
    step();
    total++; if (state !== 3'd1) $display("FAIL ar_restart: got %0d want 1", state); else passed++;
    sim_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_clock_limit();
    test_drain_timeout();
    test_simultaneous();
    test_abort_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
    $fatal(1);
  end

endmodule
